pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter CNT_W, default 8: width of the phase-length counter.
REQ-002 Parameter HIGH_CYC, default 10: dout high-phase length in clk cycles, legal range 1..2^CNT_W-1.
REQ-003 Parameter LOW_CYC, default 5: dout low-phase length between pulses, legal range 1..2^CNT_W-1.
REQ-004 Parameter PULSES, default 1: pulses per trigger, legal range 1..255.
REQ-005 Parameter RETRIG, default 0: 0 = ignore en while busy; 1 = en while busy restarts the train.
REQ-006 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port en, input, 1: trigger, synchronous to clk, sampled on rising edge.
REQ-009 Port dout, output, 1: registered pulse-train output.
REQ-010 Port busy, output, 1: registered, high whenever the state is not IDLE.
REQ-011 Port done, output, 1: registered single-cycle completion strobe.
REQ-012 Port pulse_cnt, output, 8: registered count of high phases completed in the current/last train.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, HIGH, LOW.
REQ-014 IDLE + en=1 at edge N -> HIGH; dout=1, busy=1, pulse_cnt=0, phase counter=0, all visible after edge N (latency 1 edge, no extra delay).
REQ-015 HIGH SHALL last exactly HIGH_CYC cycles: dout=1 after edges N..N+HIGH_CYC-1, phase counter increments each edge.
REQ-016 At the end of HIGH, pulse_cnt SHALL increment by 1 and the phase counter SHALL clear.
REQ-017 End of HIGH with pulse_cnt+1 < PULSES -> LOW, dout=0 for exactly LOW_CYC cycles, then -> HIGH.
REQ-018 End of HIGH with pulse_cnt+1 = PULSES -> IDLE directly (no trailing LOW); dout=0, busy=0, done=1 for exactly one cycle.
REQ-019 A train SHALL occupy PULSES*HIGH_CYC + (PULSES-1)*LOW_CYC cycles from edge N to busy falling.
REQ-020 RETRIG=0: en=1 while busy SHALL have no effect.
REQ-021 RETRIG=1: en=1 while busy (HIGH or LOW) SHALL restart as REQ-014 (state HIGH, pulse_cnt=0, counter=0, dout=1); done SHALL NOT pulse for the aborted train.
REQ-022 en=1 on the same edge that returns to IDLE SHALL be ignored for RETRIG=0 (done=1, IDLE); for RETRIG=1 it SHALL restart per REQ-021 with done=0.
REQ-023 en=1 in the cycle done=1 (state IDLE) SHALL start a new train per REQ-014; done SHALL return to 0.
REQ-024 en held high continuously SHALL, with RETRIG=0, produce back-to-back trains separated by exactly one IDLE cycle; with RETRIG=1, dout SHALL stay high and no train SHALL complete.
REQ-025 pulse_cnt SHALL hold its final value (PULSES) in IDLE until the next trigger.
REQ-026 Counters SHALL never wrap; comparisons are against HIGH_CYC-1 / LOW_CYC-1 in CNT_W bits.

Reset
REQ-027 rst_n=0 SHALL immediately, without clk, force IDLE, dout=0, busy=0, done=0, pulse_cnt=0, phase counter=0.
REQ-028 Reset asserted mid-train SHALL abort with no done pulse; after release the block SHALL wait for a fresh en.
REQ-029 en sampled at the first edge after rst_n rises SHALL be honoured.

Verification
REQ-030 Defaults, rst_n low 10 cycles, then en pulse 1 cycle -> dout high exactly 10 cycles, busy high 10 cycles, done 1 cycle after, pulse_cnt=1.
REQ-031 PULSES=3, HIGH_CYC=4, LOW_CYC=2, single en -> dout pattern 1111 00 1111 00 1111 then 0; busy 16 cycles; pulse_cnt 0,1,2,3; one done.
REQ-032 RETRIG=0, second en 3 cycles into HIGH -> ignored, dout still exactly 10 cycles high.
REQ-033 RETRIG=1, PULSES=3, HIGH_CYC=4, LOW_CYC=2, en during first LOW -> dout=1 next cycle, pulse_cnt=0, full 16-cycle train follows, single done.
REQ-034 rst_n pulsed low mid-HIGH between clock edges -> dout/busy drop immediately, no done, idle until next en.
REQ-035 Defaults, en held high 30 cycles -> 10 high, 1 low, 10 high, 1 low, ... with done at each gap.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Pulse-train generator: on en, emits PULSES high phases of HIGH_CYC cycles
// separated by LOW_CYC low cycles; busy/done/pulse_cnt report train progress.
module pulse_train_gen #(
  parameter int CNT_W    = 8,
  parameter int HIGH_CYC = 10,
  parameter int LOW_CYC  = 5,
  parameter int PULSES   = 1,
  parameter int RETRIG   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       dout,
  output logic       busy,
  output logic       done,
  output logic [7:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LOW_CYC - 1);
  localparam logic [8:0]       N_PULSE = 9'(PULSES);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [7:0]       pcnt_nx;
  logic [8:0]       pcnt_inc;
  logic             done_nx;
  logic             restart;

  assign restart  = (RETRIG != 0) && en;
  // one extra bit so PULSES=255 compares without wrapping
  assign pcnt_inc = {1'b0, pulse_cnt} + 9'd1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pcnt_nx  = pulse_cnt;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          pcnt_nx  = '0;
        end
      end
      HIGH: begin
        if (restart) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          pcnt_nx  = '0;
        end else if (cnt == HI_LAST) begin
          cnt_nx  = '0;
          pcnt_nx = pcnt_inc[7:0];
          if (pcnt_inc == N_PULSE) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = LOW;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (restart) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          pcnt_nx  = '0;
        end else if (cnt == LO_LAST) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse_cnt <= '0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pulse_cnt <= pcnt_nx;
      dout      <= (state_nx == HIGH);
      busy      <= (state_nx != IDLE);
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: three configurations checked every cycle
// against a train-position model, plus directed literal expectations.
module tb_pulse_train_gen;

  localparam int HC [3] = '{10, 4, 4};
  localparam int LC [3] = '{5, 2, 2};
  localparam int NP [3] = '{1, 3, 3};
  localparam int RT [3] = '{0, 0, 1};

  logic       clk;
  logic       rst_n;
  logic [2:0] en;
  logic [2:0] dout;
  logic [2:0] busy;
  logic [2:0] done;
  logic [7:0] pc [3];

  int checks;
  int fails;

  bit act [3];
  int t   [3];
  bit md  [3];
  int lpc [3];

  pulse_train_gen #(
    .CNT_W(8), .HIGH_CYC(10), .LOW_CYC(5), .PULSES(1), .RETRIG(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]),
    .dout(dout[0]), .busy(busy[0]), .done(done[0]), .pulse_cnt(pc[0])
  );

  pulse_train_gen #(
    .CNT_W(8), .HIGH_CYC(4), .LOW_CYC(2), .PULSES(3), .RETRIG(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]),
    .dout(dout[1]), .busy(busy[1]), .done(done[1]), .pulse_cnt(pc[1])
  );

  pulse_train_gen #(
    .CNT_W(8), .HIGH_CYC(4), .LOW_CYC(2), .PULSES(3), .RETRIG(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]),
    .dout(dout[2]), .busy(busy[2]), .done(done[2]), .pulse_cnt(pc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int train_len(int i);
    return NP[i] * HC[i] + (NP[i] - 1) * LC[i];
  endfunction

  function automatic int exp_dout(int i);
    int p = HC[i] + LC[i];
    return (act[i] && (t[i] % p) < HC[i]) ? 1 : 0;
  endfunction

  function automatic int exp_pc(int i);
    int p = HC[i] + LC[i];
    if (!act[i]) return lpc[i];
    return t[i] / p + (((t[i] % p) >= HC[i]) ? 1 : 0);
  endfunction

  // t = cycles elapsed since the start edge of the current train
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0;
        t[i]   = 0;
        md[i]  = 1'b0;
        lpc[i] = 0;
      end else if (!act[i]) begin
        md[i] = 1'b0;
        if (en[i]) begin
          act[i] = 1'b1;
          t[i]   = 0;
        end
      end else if (RT[i] != 0 && en[i]) begin
        t[i]  = 0;
        md[i] = 1'b0;
      end else begin
        t[i]  = t[i] + 1;
        md[i] = 1'b0;
        if (t[i] == train_len(i)) begin
          act[i] = 1'b0;
          md[i]  = 1'b1;
          lpc[i] = NP[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.dout", i), int'(dout[i]), exp_dout(i));
      check($sformatf("u%0d.busy", i), int'(busy[i]), int'(act[i]));
      check($sformatf("u%0d.done", i), int'(done[i]), int'(md[i]));
      check($sformatf("u%0d.pulse_cnt", i), int'(pc[i]), exp_pc(i));
    end
  end

  int         hi0, bz0, dn0;
  int         bz1, dn1;
  int         hi2, bz2, dn2;
  logic [16:0] pat;

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    en     = '0;
    repeat (10) @(negedge clk);
    check("reset.dout", int'(dout), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.pc1", int'(pc[1]), 0);
    rst_n = 1'b1;

    // single triggers on default and 3-pulse configs
    en = 3'b011;
    @(negedge clk);
    en = '0;
    hi0 = 0; bz0 = 0; dn0 = 0; bz1 = 0; dn1 = 0; pat = '0;
    for (int k = 0; k < 25; k++) begin
      hi0 += int'(dout[0]);
      bz0 += int'(busy[0]);
      dn0 += int'(done[0]);
      bz1 += int'(busy[1]);
      dn1 += int'(done[1]);
      if (k < 17) pat = {pat[15:0], dout[1]};
      @(negedge clk);
    end
    check("s1.u0_high", hi0, 10);
    check("s1.u0_busy", bz0, 10);
    check("s1.u0_done", dn0, 1);
    check("s1.u0_pc", int'(pc[0]), 1);
    check("s1.u1_pattern", int'(pat), int'(17'b11110011110011110));
    check("s1.u1_busy", bz1, 16);
    check("s1.u1_done", dn1, 1);
    check("s1.u1_pc", int'(pc[1]), 3);

    // ignored re-trigger on u0, restart during LOW on u2
    en = 3'b101;
    @(negedge clk);
    en = '0;
    hi0 = 0; dn0 = 0; bz2 = 0; dn2 = 0;
    for (int k = 0; k < 31; k++) begin
      hi0 += int'(dout[0]);
      dn0 += int'(done[0]);
      bz2 += int'(busy[2]);
      dn2 += int'(done[2]);
      if (k == 4) check("s2.u2_in_low", int'(dout[2]), 0);
      if (k == 5) begin
        check("s2.u2_restart_dout", int'(dout[2]), 1);
        check("s2.u2_restart_pc", int'(pc[2]), 0);
      end
      en = (k == 3) ? 3'b001 : (k == 4) ? 3'b100 : 3'b000;
      @(negedge clk);
    end
    check("s2.u0_high", hi0, 10);
    check("s2.u0_done", dn0, 1);
    check("s2.u2_busy", bz2, 21);
    check("s2.u2_done", dn2, 1);

    // en held high
    en = 3'b101;
    @(negedge clk);
    hi0 = 0; dn0 = 0; hi2 = 0; dn2 = 0;
    for (int k = 0; k < 30; k++) begin
      hi0 += int'(dout[0]);
      dn0 += int'(done[0]);
      hi2 += int'(dout[2]);
      dn2 += int'(done[2]);
      if (k == 10 || k == 21) check("s4.u0_gap", int'(dout[0]), 0);
      @(negedge clk);
    end
    en = '0;
    check("s4.u0_high", hi0, 28);
    check("s4.u0_done", dn0, 2);
    check("s4.u2_high", hi2, 30);
    check("s4.u2_done", dn2, 0);
    repeat (20) @(negedge clk);

    // asynchronous reset mid-HIGH, then trigger sampled at first edge
    en = 3'b001;
    @(negedge clk);
    en = '0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("s3.async_dout", int'(dout[0]), 0);
    check("s3.async_busy", int'(busy[0]), 0);
    en = 3'b010;
    #1 rst_n = 1'b1;
    @(negedge clk);
    en = '0;
    check("s3.first_edge_busy", int'(busy[1]), 1);
    check("s3.first_edge_dout", int'(dout[1]), 1);
    bz0 = 0; dn0 = 0;
    for (int k = 0; k < 15; k++) begin
      bz0 += int'(busy[0]);
      dn0 += int'(done[0]);
      @(negedge clk);
    end
    check("s3.u0_stays_idle", bz0, 0);
    check("s3.u0_no_done", dn0, 0);
    repeat (10) @(negedge clk);

    // randomized triggers and occasional asynchronous resets
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 3; i++)
        en[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    en = '0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
